// File: rtl/vend_coin_driver_if.sv
// ---------------------------------------------------------------------------
// vend_coin_driver_if
//   Bundles the request, coin-bus, machine-response and result signals of the
//   vending-machine coin driver into one interface.
//
//   master : the coin driver itself.
//            It takes the request and the pr/ch response as inputs.
//            It drives the coin bus, the status outputs and the counters.
//   slave  : the environment.
//            It issues requests, models the machine's pr/ch response and
//            consumes the results.
//
//   Signals
//     start        request a transaction (accepted only while busy=0)
//     seq_len      number of coins, 1..MAX_COINS
//     seq_coins    packed coin codes; coin i sits at [2i+1:2i]
//     busy         transaction in progress
//     coin         coin bus: 00 none, 01 one unit, 10 two units
//     pr, ch       product-release / change-return from the machine
//     done         one-cycle end-of-transaction pulse
//     vend_seen    pr was seen during the transaction
//     change_seen  ch was seen during the transaction
//     result_ok    observed outcome matches the expected outcome
//     err_code     0 none, 1 bad request, 2 timeout, 3 early vend
//     vend_cnt     saturating count of transactions that ended with a vend
//     change_cnt   saturating count of transactions that ended with change
// ---------------------------------------------------------------------------
interface vend_coin_driver_if #(
  parameter int MAX_COINS = 4,
  parameter int CNT_W     = 8
);
  logic                   start;
  logic [2:0]             seq_len;
  logic [2*MAX_COINS-1:0] seq_coins;
  logic                   busy;
  logic [1:0]             coin;
  logic                   pr;
  logic                   ch;
  logic                   done;
  logic                   vend_seen;
  logic                   change_seen;
  logic                   result_ok;
  logic [1:0]             err_code;
  logic [CNT_W-1:0]       vend_cnt;
  logic [CNT_W-1:0]       change_cnt;

  modport master (
    input  start, seq_len, seq_coins, pr, ch,
    output busy, coin, done, vend_seen, change_seen, result_ok, err_code,
           vend_cnt, change_cnt
  );

  modport slave (
    output start, seq_len, seq_coins, pr, ch,
    input  busy, coin, done, vend_seen, change_seen, result_ok, err_code,
           vend_cnt, change_cnt
  );
endinterface

// File: rtl/vend_coin_driver.sv
// ---------------------------------------------------------------------------
// vend_coin_driver
//   Customer-side initiator for the vending-machine coin interface.
//
//   Operation
//     On start it latches a coin sequence.
//     It drives one coin per clock onto the coin bus.
//     It then watches the machine's pr/ch response.
//     At the end it reports whether the response matched the amount paid.
//
//   State sequence
//     IDLE -> DRIVE -> WAIT -> FIN -> IDLE
//     A malformed request goes straight from IDLE to FIN.
//
//   Timing
//     FIN computes the results.
//     done, result_ok and the counters therefore become visible in the cycle
//     after FIN, when the FSM is back in IDLE.
//
//   Parameters
//     MAX_COINS  max coins per transaction (1..7)
//     PRICE      product price in coin units
//     TIMEOUT    WAIT cycles allowed for pr before giving up (>=2)
//     CNT_W      width of the statistics counters
//
//   Ports
//     clk     rising-edge clock
//     rstn    asynchronous active-low reset
//     io_bus  vend_coin_driver_if.master
//             Carries the request, coin bus, pr/ch and the results.
// ---------------------------------------------------------------------------
module vend_coin_driver #(
  parameter int MAX_COINS = 4,
  parameter int PRICE     = 3,
  parameter int TIMEOUT   = 8,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  vend_coin_driver_if.master        io_bus
);

  localparam int SUM_W = $clog2(2*MAX_COINS+1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int SEQ_W = 2*MAX_COINS;

  localparam logic [2:0]       MAX_LEN  = 3'(MAX_COINS);
  localparam logic [SUM_W-1:0] PRICE_S  = SUM_W'(PRICE);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT-1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_REQ = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_EARLY   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  // Codes 00 and 11 are not coins.
  function automatic logic coin_is_bad(input logic [1:0] code);
    return (code == 2'b00) || (code == 2'b11);
  endfunction

  // Value of a coin code in price units.
  function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] code);
    logic [SUM_W-1:0] val;
    case (code)
      2'b01:   val = SUM_W'(1);
      2'b10:   val = SUM_W'(2);
      default: val = SUM_W'(0);
    endcase
    return val;
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (&val) begin
      res = val;
    end else begin
      res = val + CNT_W'(1);
    end
    return res;
  endfunction

  state_t             r_state;
  logic               r_busy;
  logic [1:0]         r_coin;
  logic [2:0]         r_len;
  logic [SEQ_W-1:0]   r_coins;
  logic [2:0]         r_idx;        // coins already put on the bus
  logic [SUM_W-1:0]   r_sum;
  logic [TMR_W-1:0]   r_timer;
  logic               r_vend_seen;
  logic               r_change_seen;
  logic [1:0]         r_err;
  logic               r_done;
  logic               r_result_ok;
  logic [CNT_W-1:0]   r_vend_cnt;
  logic [CNT_W-1:0]   r_change_cnt;

  logic               w_bad_code;
  logic               w_req_bad;
  logic [SEQ_W-1:0]   w_shifted;
  logic [1:0]         w_next_code;
  logic               w_coins_left;

  // Request validation: only the first seq_len codes have to be real coins.
  always_comb begin
    w_bad_code = 1'b0;
    for (int i = 0; i < MAX_COINS; i++) begin
      w_bad_code = w_bad_code |
                   ((3'(i) < io_bus.seq_len) & coin_is_bad(io_bus.seq_coins[2*i +: 2]));
    end
    w_req_bad = (io_bus.seq_len == 3'd0) | (io_bus.seq_len > MAX_LEN) | w_bad_code;
  end

  // Next coin to send: code at index r_idx of the latched sequence.
  always_comb begin
    w_shifted    = r_coins >> {r_idx, 1'b0};
    w_next_code  = w_shifted[1:0];
    w_coins_left = (r_idx < r_len);
  end

  // Transaction FSM with its registered outputs, flags and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_coin        <= 2'b00;
      r_len         <= 3'd0;
      r_coins       <= '0;
      r_idx         <= 3'd0;
      r_sum         <= '0;
      r_timer       <= '0;
      r_vend_seen   <= 1'b0;
      r_change_seen <= 1'b0;
      r_err         <= ERR_NONE;
      r_done        <= 1'b0;
      r_result_ok   <= 1'b0;
      r_vend_cnt    <= '0;
      r_change_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_coin <= 2'b00;
          if (io_bus.start) begin
            r_len         <= io_bus.seq_len;
            r_coins       <= io_bus.seq_coins;
            r_vend_seen   <= 1'b0;
            r_change_seen <= 1'b0;
            r_result_ok   <= 1'b0;
            r_timer       <= '0;
            r_busy        <= 1'b1;
            if (w_req_bad) begin
              r_err   <= ERR_BAD_REQ;
              r_sum   <= '0;
              r_idx   <= 3'd0;
              r_state <= S_FIN;
            end else begin
              // The first coin goes out on the edge that accepts the request.
              r_err   <= ERR_NONE;
              r_coin  <= io_bus.seq_coins[1:0];
              r_idx   <= 3'd1;
              r_sum   <= coin_value(io_bus.seq_coins[1:0]);
              r_state <= S_DRIVE;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end

        S_DRIVE: begin
          r_vend_seen   <= r_vend_seen | io_bus.pr;
          r_change_seen <= r_change_seen | io_bus.ch;
          if (io_bus.pr && w_coins_left) begin
            // Machine vended before it was fully paid: abandon the rest.
            r_coin  <= 2'b00;
            r_err   <= ERR_EARLY;
            r_timer <= '0;
            r_state <= S_WAIT;
          end else if (w_coins_left) begin
            r_coin <= w_next_code;
            r_idx  <= r_idx + 3'd1;
            r_sum  <= r_sum + coin_value(w_next_code);
          end else begin
            r_coin  <= 2'b00;
            r_timer <= '0;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          r_vend_seen   <= r_vend_seen | io_bus.pr;
          r_change_seen <= r_change_seen | io_bus.ch;
          r_coin        <= 2'b00;
          if (r_vend_seen) begin
            // This was the extra cycle after pr, kept only to catch a late ch.
            r_state <= S_FIN;
          end else if (io_bus.pr) begin
            r_state <= S_WAIT;
          end else if (r_timer == TMR_LAST) begin
            // No vend at all: an error only if enough was paid to expect one.
            if (r_sum >= PRICE_S) begin
              r_err <= ERR_TIMEOUT;
            end else begin
              r_err <= r_err;
            end
            r_state <= S_FIN;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        S_FIN: begin
          r_coin      <= 2'b00;
          r_done      <= 1'b1;
          r_result_ok <= (r_vend_seen == (r_sum >= PRICE_S)) &&
                         (r_change_seen == (r_sum > PRICE_S)) &&
                         (r_err == ERR_NONE);
          if (r_vend_seen) begin
            r_vend_cnt <= sat_inc(r_vend_cnt);
          end else begin
            r_vend_cnt <= r_vend_cnt;
          end
          if (r_change_seen) begin
            r_change_cnt <= sat_inc(r_change_cnt);
          end else begin
            r_change_cnt <= r_change_cnt;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_coin  <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.busy        = r_busy;
  assign io_bus.coin        = r_coin;
  assign io_bus.done        = r_done;
  assign io_bus.vend_seen   = r_vend_seen;
  assign io_bus.change_seen = r_change_seen;
  assign io_bus.result_ok   = r_result_ok;
  assign io_bus.err_code    = r_err;
  assign io_bus.vend_cnt    = r_vend_cnt;
  assign io_bus.change_cnt  = r_change_cnt;

endmodule
